// File: rtl/io_pkg.sv
// Shared definitions for the I/O output port bank: write-mode encodings,
// pulse-length register index offset, default base index, the per-port
// auto-clear state type and the byte-lane merge helper.
package io_pkg;

  // Write mode carried in addr[9:8]
  localparam logic [1:0] IO_MODE_WR  = 2'b00;
  localparam logic [1:0] IO_MODE_SET = 2'b01;
  localparam logic [1:0] IO_MODE_CLR = 2'b10;
  localparam logic [1:0] IO_MODE_TGL = 2'b11;

  // Pulse-length register of port p lives at word index BASE_IDX + offset + p
  localparam int unsigned IO_PLEN_OFFSET = 8;

  // Default word index (addr[7:2]) of port 0, i.e. byte address 0x80
  localparam logic [5:0] IO_BASE_IDX_DEFAULT = 6'b100000;

  // Per-port auto-clear state
  typedef enum logic {
    PULSE_IDLE  = 1'b0,
    PULSE_COUNT = 1'b1
  } pulse_state_t;

  // Apply one write mode to a single byte lane
  function automatic logic [7:0] merge_byte(input logic [1:0] mode,
                                            input logic [7:0] cur,
                                            input logic [7:0] din);
    logic [7:0] res;
    case (mode)
      IO_MODE_WR:  res = din;
      IO_MODE_SET: res = cur | din;
      IO_MODE_CLR: res = cur & ~din;
      default:     res = cur ^ din;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_output_bank_if.sv
// CPU-side bus of the I/O output port bank.
//
// Strobe semantics: write_io_enable and read_io_enable are single-cycle
// strobes qualified by addr/datain/byte_en in the same cycle. There is no
// ready: the bank accepts a strobe on every cycle. A read strobe always
// produces io_rvalid high for exactly one cycle on the next cycle, with
// io_rdata valid alongside it and held until the next read.
interface io_output_bank_if #(
  parameter int DW = 32
);
  logic [31:0]     addr;
  logic [DW-1:0]   datain;
  logic [DW/8-1:0] byte_en;
  logic            write_io_enable;
  logic            read_io_enable;
  logic [DW-1:0]   io_rdata;
  logic            io_rvalid;

  modport master (
    output addr, datain, byte_en, write_io_enable, read_io_enable,
    input  io_rdata, io_rvalid
  );

  modport slave (
    input  addr, datain, byte_en, write_io_enable, read_io_enable,
    output io_rdata, io_rvalid
  );
endinterface

// File: rtl/io_out_lane.sv
// One output port: port register with byte-lane write-mode merge.
// When IO_OUT_PULSE_EN is defined the lane also carries a pulse-length
// register and a down-counter that clears the port when it expires.
module io_out_lane
  import io_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            io_clk,
  input  logic            resetn,
  input  logic            wr_port,
  input  logic            wr_plen,
  input  logic [1:0]      mode,
  input  logic [DW-1:0]   datain,
  input  logic [DW/8-1:0] byte_en,
  output logic [DW-1:0]   port_q,
  output logic [CW-1:0]   plen_q,
  output logic            pulse_active
);

  logic [DW-1:0] merged;

  // Next port value: each enabled lane gets the mode applied, others keep
  always_comb begin
    merged = port_q;
    for (int i = 0; i < DW / 8; i++) begin
      if (byte_en[i]) begin
        merged[i*8 +: 8] = merge_byte(mode, port_q[i*8 +: 8], datain[i*8 +: 8]);
      end
    end
  end

`ifdef IO_OUT_PULSE_EN

  pulse_state_t  state;
  logic [CW-1:0] cnt;

  assign pulse_active = (state == PULSE_COUNT);

  // Pulse-length register: plain writes only, byte enables on the low CW bits
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      plen_q <= '0;
    end else if (wr_plen && (mode == IO_MODE_WR)) begin
      for (int b = 0; b < CW; b++) begin
        if (byte_en[b / 8]) begin
          plen_q[b] <= datain[b];
        end
      end
    end
  end

  // Port register with auto-clear FSM; a write always wins over expiry
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      port_q <= '0;
      cnt    <= '0;
      state  <= PULSE_IDLE;
    end else if (wr_port) begin
      port_q <= merged;
      if (plen_q != '0) begin
        cnt   <= plen_q;
        state <= PULSE_COUNT;
      end else begin
        cnt   <= '0;
        state <= PULSE_IDLE;
      end
    end else begin
      case (state)
        PULSE_COUNT: begin
          if (cnt <= CW'(1)) begin
            port_q <= '0;
            cnt    <= '0;
            state  <= PULSE_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

`else

  logic unused_plen_wr;

  assign plen_q         = '0;
  assign pulse_active   = 1'b0;
  assign unused_plen_wr = wr_plen;

  // Port register holds its value until rewritten
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      port_q <= '0;
    end else if (wr_port) begin
      port_q <= merged;
    end
  end

`endif

endmodule

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank on the CPU I/O path: NPORTS ports of DW
// bits with byte-lane set/clear/toggle writes and registered readback.
// Optional feature macro: IO_OUT_PULSE_EN adds a per-port one-shot
// auto-clear timer with its pulse-length register at BASE_IDX + 8 + p.
module io_output_bank
  import io_pkg::*;
#(
  parameter int         NPORTS   = 3,
  parameter int         DW       = 32,
  parameter logic [5:0] BASE_IDX = IO_BASE_IDX_DEFAULT,
  parameter int         CW       = 16
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  io_output_bank_if.slave      bus,
  output logic [NPORTS*DW-1:0] out_port,
  output logic [NPORTS-1:0]    pulse_active
);

  logic [5:0]        word_idx;
  logic [1:0]        mode;
  logic [NPORTS-1:0] port_hit;
  logic [NPORTS-1:0] plen_hit;
  logic [DW-1:0]     port_q [NPORTS];
  logic [CW-1:0]     plen_q [NPORTS];
  logic [DW-1:0]     rd_next;
  logic              unused_addr;

  assign word_idx    = bus.addr[7:2];
  assign mode        = bus.addr[9:8];
  assign unused_addr = ^{bus.addr[31:10], bus.addr[1:0]};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    localparam logic [5:0] PORT_IDX = BASE_IDX + 6'(p);
    localparam logic [5:0] PLEN_IDX = BASE_IDX + 6'(IO_PLEN_OFFSET) + 6'(p);

    assign port_hit[p] = (word_idx == PORT_IDX);
    assign plen_hit[p] = (word_idx == PLEN_IDX);

    io_out_lane #(
      .DW (DW),
      .CW (CW)
    ) u_lane (
      .io_clk       (io_clk),
      .resetn       (resetn),
      .wr_port      (bus.write_io_enable && port_hit[p]),
      .wr_plen      (bus.write_io_enable && plen_hit[p]),
      .mode         (mode),
      .datain       (bus.datain),
      .byte_en      (bus.byte_en),
      .port_q       (port_q[p]),
      .plen_q       (plen_q[p]),
      .pulse_active (pulse_active[p])
    );

    assign out_port[p*DW +: DW] = port_q[p];
  end

  // Readback select: port word, zero-extended plen, or 0 when unmapped
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_hit[p]) begin
        rd_next = port_q[p];
      end
`ifdef IO_OUT_PULSE_EN
      if (plen_hit[p]) begin
        rd_next = '0;
        rd_next[CW-1:0] = plen_q[p];
      end
`endif
    end
  end

  // Registered readback; samples pre-write state so a same-cycle write is not seen
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      bus.io_rdata  <= '0;
      bus.io_rvalid <= 1'b0;
    end else begin
      bus.io_rvalid <= bus.read_io_enable;
      if (bus.read_io_enable) begin
        bus.io_rdata <= rd_next;
      end
    end
  end

endmodule

// File: doc/io_output_bank.md
# io_output_bank

Parametrised memory-mapped output port bank for the CPU's I/O space. It replaces the fixed three-port output register with NPORTS ports of DW bits. Features:
- byte-lane writes;
- atomic set, clear and toggle write modes;
- registered readback;
- an optional per-port one-shot auto-clear timer.

It sits on the data-memory I/O path, alongside data memory, and is written by store instructions whose address decodes to I/O.

## Interface
- NPORTS, 3: number of output ports (1..8).
- DW, 32: port and bus data width; must be a multiple of 8.
- BASE_IDX, 6'b100000: word index `addr[7:2]` of port 0.
- CW, 16: pulse counter width. Used only when IO_OUT_PULSE_EN is defined.

Ports:
- io_clk  in  1  the single clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- addr  in  32  byte address; bits [9:8] select the mode, bits [7:2] select the word.
- datain  in  DW  write data.
- byte_en  in  DW/8  write byte-lane strobes.
- write_io_enable  in  1  write strobe, one cycle.
- read_io_enable  in  1  read strobe, one cycle.
- io_rdata  out  DW  readback data.
- io_rvalid  out  1  readback valid, one-cycle pulse.
- out_port  out  NPORTS*DW  concatenated port outputs; port p occupies [p*DW +: DW].

## Operation
- **Port decode.** Port p is selected when `addr[7:2] == BASE_IDX + p` and p < NPORTS. Any other index is ignored on write and reads back 0.
- **Write modes.** The mode is `addr[9:8]`; only byte lanes with `byte_en` high are affected.
  - 00 write: lane = datain.
  - 01 set: lane |= datain.
  - 10 clear: lane &= ~datain.
  - 11 toggle: lane ^= datain.
- **Read.** On `read_io_enable`, io_rdata captures the addressed port's current value, or a pulse-length register (see Configuration), or 0 for an unmapped index. io_rvalid is asserted for that one cycle.
  - Mode bits are ignored on reads.
  - A read and a write to the same port in the same cycle return the pre-write value.
- **Reset.** Asserting resetn low immediately clears, regardless of io_clk:
  - all out_port words;
  - io_rdata and io_rvalid;
  - all counters and pulse-length registers.

## Timing
- Write latency is 1 cycle: out_port reflects the write after the io_clk edge on which write_io_enable is sampled high.
- Read latency is 1 cycle: io_rdata and io_rvalid are valid in the cycle after the strobe. io_rdata holds its value until the next read; io_rvalid is high for exactly one cycle.
- There is no backpressure. A strobe may be asserted every cycle, and back-to-back writes to one port apply in order.
- When write_io_enable and read_io_enable are high together, both are serviced.
- Release of resetn is synchronised by the system; no first-edge requirements apply here.

## Configuration
- Macro: IO_OUT_PULSE_EN.
- **Defined:** each port p has a CW-bit pulse-length register `plen[p]` at word index `BASE_IDX + 8 + p`.
  - It is written with mode 00 only, and only from the low CW bits. Byte enables apply to those bits; writes with mode ≠ 00 are ignored.
  - Readback is zero-extended.
- **Counter behaviour (defined):** each port has a down-counter `cnt[p]` and is in one of two states, IDLE or COUNT.
  - IDLE → COUNT on any write to port p when `plen[p] != 0`; the write loads `cnt = plen[p]`.
  - COUNT decrements every cycle. At the cycle where cnt would reach 0, the port word is cleared to 0 and the port returns to IDLE.
  - A write to port p while in COUNT takes effect and reloads the counter, and the write beats expiry in the same cycle.
  - A plen write during COUNT does not change the running count; the new value applies on the next load.
  - `plen = 0` disables auto-clear.
  - With `plen = 1`, the port holds the written value for exactly 1 cycle.
- **Not defined:** no counters or plen registers exist. Indices `BASE_IDX + 8 + p` are unmapped and read 0. Ports hold their value until rewritten.

## Structure
- Shared package `io_pkg` holds:
  - the mode encodings `IO_MODE_WR`, `IO_MODE_SET`, `IO_MODE_CLR`, `IO_MODE_TGL`;
  - the pulse-register index offset, 8;
  - the default BASE_IDX.
- One sub-module: `io_out_lane`. It is instantiated once per port and holds:
  - the port register;
  - the byte-lane mode merge logic;
  - under the macro, the counter and plen register together with the IDLE/COUNT state.
- The top-level module holds the address decode and the registered readback mux.

## Test plan
- **Reset and basic write.** Hold resetn low → all out_port words are 0 and io_rvalid is 0. With defaults, write 0xDEADBEEF to addr 0x80 with `byte_en = 4'hF` → port0 = 0xDEADBEEF the next cycle; ports 1 and 2 are unchanged.
- **Modes and byte lanes.**
  1. Port1 = 0x0000FFFF.
  2. Set at addr 0x184, data 0xFF000000 → 0xFF00FFFF.
  3. Clear at 0x284, data 0x000000F0 → 0xFF00FF0F.
  4. Toggle at 0x384, data 0xFFFFFFFF, `byte_en = 4'b0001` → 0xFF00FFF0.
- **Readback.** Read and write port2 (addr 0x88) in the same cycle: the old value is returned with io_rvalid high for 1 cycle. A read of unmapped index 0x8C returns 0.
- **Pulse (macro defined).**
  1. Set `plen[0] = 3` at addr 0xA0.
  2. Write port0 = 0x1 → port0 = 0x1 for exactly 3 cycles, then 0.
  3. Rewrite port0 at the expiry cycle → the written value stays, and it clears 3 cycles later.
- **Async reset mid-count.** Drop resetn during COUNT without an io_clk edge → port0 = 0 immediately; after release, port0 stays 0 and no stale expiry occurs.
- **Macro undefined.** Write port0 = 0x5 → port0 holds 0x5 for 100 cycles. A read of 0xA0 returns 0.
